// File: rtl/trap_shaper_cfg.sv
// Trapezoidal pulse shaper with runtime-loadable k/l/M/shift/bypass and a 4-edge pipeline.
// Handshake: a sample is taken on an edge with in_valid & in_ready; in_ready is low outside RUN, during cfg_load and reset.
module trap_shaper_cfg #(
  parameter int DATA_W  = 16,
  parameter int ACC_W   = 40,
  parameter int DEPTH   = 64,
  parameter int M_W     = 16,
  parameter int K_DEF   = 4,
  parameter int L_DEF   = 8,
  parameter int M_DEF   = 0,
  parameter int SH_DEF  = 0,
  parameter int BYP_DEF = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_W-1:0]            in_data,
  input  logic                         cfg_load,
  input  logic [$clog2(DEPTH+1)-1:0]   cfg_k,
  input  logic [$clog2(DEPTH+1)-1:0]   cfg_l,
  input  logic [M_W-1:0]               cfg_m,
  input  logic [4:0]                   cfg_shift,
  input  logic                         cfg_bypass,
  output logic                         cfg_err,
  output logic                         out_valid,
  output logic [DATA_W-1:0]            out_data,
  output logic                         out_settled,
  output logic                         ovf_sticky
);

  localparam int CW  = $clog2(DEPTH+1);
  localparam int DW  = DATA_W + 2;
  localparam int MDW = M_W + 1 + DW;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

  state_t                   state_q, state_d;
  logic [CW-1:0]            k_q, k_d, l_q, l_d;
  logic [M_W-1:0]           m_q, m_d;
  logic [4:0]               sh_q, sh_d;
  logic                     byp_q, byp_d;
  logic [DATA_W-1:0]        dl_q [DEPTH+1];
  logic [DATA_W-1:0]        dl_d [DEPTH+1];
  logic                     v0_q, v0_d, v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic signed [DW-1:0]     d1_q, d1_d, d2_q, d2_d;
  logic signed [MDW-1:0]    md_q, md_d;
  logic signed [ACC_W-1:0]  p_q, p_d, s_q, s_d;
  logic                     out_valid_q, out_valid_d;
  logic [DATA_W-1:0]        out_data_q, out_data_d;
  logic                     settled_q, settled_d, ovf_q, ovf_d, cfg_err_q, cfg_err_d;
  logic [CW:0]              cnt_q, cnt_d;

  logic [CW:0]              kl_sum, kl_cfg;
  logic [CW-1:0]            kl_idx;
  logic signed [DW-1:0]     tap0, tapk, tapl, tapkl;
  logic signed [MDW-1:0]    m_ext, d1_wide;
  logic signed [ACC_W-1:0]  d1_acc, d2_acc, md_acc, s_shift;
  logic                     cfg_ok, accept, load_ok, load_bad;

  // Combinational ready so a cfg_load cycle never also swallows a sample.
  assign in_ready = (state_q == ST_RUN) && !cfg_load && !reset;
  assign accept   = in_valid && in_ready;

  assign kl_cfg   = {1'b0, cfg_k} + {1'b0, cfg_l};
  assign cfg_ok   = (cfg_k != '0) && (cfg_k <= cfg_l) && (kl_cfg <= (CW+1)'(DEPTH));
  assign load_ok  = (state_q == ST_RUN) && cfg_load && cfg_ok;
  assign load_bad = (state_q == ST_RUN) && cfg_load && !cfg_ok;

  assign kl_sum = {1'b0, k_q} + {1'b0, l_q};
  assign kl_idx = kl_sum[CW-1:0];

  // dl_q[0] is x[n]; dl_q[i] is x[n-i].
  assign tap0  = {{2{dl_q[0][DATA_W-1]}},      dl_q[0]};
  assign tapk  = {{2{dl_q[k_q][DATA_W-1]}},    dl_q[k_q]};
  assign tapl  = {{2{dl_q[l_q][DATA_W-1]}},    dl_q[l_q]};
  assign tapkl = {{2{dl_q[kl_idx][DATA_W-1]}}, dl_q[kl_idx]};

  assign m_ext   = {{(MDW-M_W){1'b0}}, m_q};
  assign d1_wide = {{(MDW-DW){d1_q[DW-1]}}, d1_q};
  assign d1_acc  = {{(ACC_W-DW){d1_q[DW-1]}}, d1_q};
  assign d2_acc  = {{(ACC_W-DW){d2_q[DW-1]}}, d2_q};
  assign md_acc  = {{(ACC_W-MDW){md_q[MDW-1]}}, md_q};
  assign s_shift = s_q >>> sh_q;

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    l_d         = l_q;
    m_d         = m_q;
    sh_d        = sh_q;
    byp_d       = byp_q;
    dl_d        = dl_q;
    p_d         = p_q;
    s_d         = s_q;
    out_data_d  = out_data_q;
    settled_d   = settled_q;
    ovf_d       = ovf_q;
    cnt_d       = cnt_q;
    cfg_err_d   = 1'b0;

    v0_d = accept;
    if (accept) begin
      for (int i = DEPTH; i > 0; i--) dl_d[i] = dl_q[i-1];
      dl_d[0] = in_data;
    end

    v1_d = v0_q;
    d1_d = tap0 - tapk - tapl + tapkl;

    v2_d = v1_q;
    d2_d = d1_q;
    md_d = m_ext * d1_wide;
    if (v1_q) p_d = p_q + d1_acc;

    // p_q already holds p_new for the sample now in stage 3.
    v3_d = v2_q;
    if (v2_q) s_d = s_q + (byp_q ? d2_acc : (p_q + md_acc));

    out_valid_d = v3_q;
    if (v3_q) begin
      if (s_shift > SAT_MAX) begin
        out_data_d = SAT_MAX[DATA_W-1:0];
        ovf_d      = 1'b1;
      end else if (s_shift < SAT_MIN) begin
        out_data_d = SAT_MIN[DATA_W-1:0];
        ovf_d      = 1'b1;
      end else begin
        out_data_d = s_shift[DATA_W-1:0];
      end
      if (cnt_q < kl_sum) cnt_d = cnt_q + (CW+1)'(1);
      settled_d = (cnt_d >= kl_sum);
    end

    // The sample leaving stage 3 this edge still emerges; younger ones are dropped.
    if (load_ok) begin
      k_d     = cfg_k;
      l_d     = cfg_l;
      m_d     = cfg_m;
      sh_d    = cfg_shift;
      byp_d   = cfg_bypass;
      v0_d    = 1'b0;
      v1_d    = 1'b0;
      v2_d    = 1'b0;
      v3_d    = 1'b0;
      state_d = ST_CLEAR;
    end
    if (load_bad) cfg_err_d = 1'b1;

    if (state_q == ST_CLEAR) begin
      for (int i = 0; i <= DEPTH; i++) dl_d[i] = '0;
      p_d         = '0;
      s_d         = '0;
      v0_d        = 1'b0;
      v1_d        = 1'b0;
      v2_d        = 1'b0;
      v3_d        = 1'b0;
      out_valid_d = 1'b0;
      cnt_d       = '0;
      settled_d   = 1'b0;
      ovf_d       = 1'b0;
      state_d     = ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_CLEAR;
      k_q         <= CW'(K_DEF);
      l_q         <= CW'(L_DEF);
      m_q         <= M_W'(M_DEF);
      sh_q        <= 5'(SH_DEF);
      byp_q       <= 1'(BYP_DEF);
      for (int i = 0; i <= DEPTH; i++) dl_q[i] <= '0;
      v0_q        <= 1'b0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      v3_q        <= 1'b0;
      d1_q        <= '0;
      d2_q        <= '0;
      md_q        <= '0;
      p_q         <= '0;
      s_q         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      settled_q   <= 1'b0;
      ovf_q       <= 1'b0;
      cfg_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      l_q         <= l_d;
      m_q         <= m_d;
      sh_q        <= sh_d;
      byp_q       <= byp_d;
      dl_q        <= dl_d;
      v0_q        <= v0_d;
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      v3_q        <= v3_d;
      d1_q        <= d1_d;
      d2_q        <= d2_d;
      md_q        <= md_d;
      p_q         <= p_d;
      s_q         <= s_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      settled_q   <= settled_d;
      ovf_q       <= ovf_d;
      cfg_err_q   <= cfg_err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign cfg_err     = cfg_err_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_settled = settled_q;
  assign ovf_sticky  = ovf_q;

endmodule
